serial_shift_ctrl: RTL and testbench
====================================

SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 Parameter: N, default 8, data word width in bits; legal range N >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream word available.
REQ-005 Port: in_data  input  N  parallel word to serialize.
REQ-006 Port: in_ready  output  1  controller can accept a word.
REQ-007 Port: tick  input  1  bit-rate enable; one bit advances per cycle with tick=1.
REQ-008 Port: so  output  1  serial data out, LSB first.
REQ-009 Port: so_active  output  1  so carries a frame bit.
REQ-010 Port: done  output  1  one-cycle pulse at frame end.

Function
REQ-011 The block SHALL contain an N-bit right-shift register, a bit counter of width $clog2(N) and an FSM with states IDLE, SHIFT, PARITY, DONE.
REQ-012 IDLE: in_ready=1, so=1, so_active=0; on in_valid&&in_ready, load the shift register with in_data, clear the bit counter and enter SHIFT next cycle.
REQ-013 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored, with no data captured.
REQ-014 SHIFT: so=shreg[0], so_active=1; on tick, shift right with 0 entering the MSB and increment the bit counter; without tick, hold all state.
REQ-015 SHIFT exit: tick with bit counter == N-1 SHALL go to PARITY (when PARITY_EN is defined) or DONE (when it is not).
REQ-016 PARITY: so=parity bit, so_active=1; on tick go to DONE; without tick, hold.
REQ-017 DONE: done=1 for exactly one cycle, so=1, so_active=0, in_ready=0; unconditionally go to IDLE.
REQ-018 Latency with tick tied high and PARITY_EN undefined:
  - word accepted at cycle 0
  - bit k on so during cycle k+1 (k = 0..N-1)
  - done at cycle N+1
  - in_ready high again at cycle N+2
REQ-019 With PARITY_EN defined, the parity bit occupies cycle N+1 and done and in_ready each shift one cycle later.
REQ-020 tick in IDLE or DONE SHALL have no effect.
REQ-021 done and so_active SHALL be registered, glitch-free outputs decoded from state only.

Reset
REQ-022 While reset=1, asynchronously and independent of clk:
  - state=IDLE
  - shift register=0
  - bit counter=0
  - parity register=0
  - so=1, so_active=0, done=0, in_ready=1
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first accept is possible on the first clk edge after reset deassertion.

Configuration
REQ-024 Macro PARITY_EN: when defined, the even-parity bit (XOR of in_data) is captured at load and sent after the data bits in state PARITY.
REQ-025 When PARITY_EN is undefined, the PARITY state, the parity register and the parity logic SHALL not exist, and SHIFT goes directly to DONE.

Verification
REQ-026 N=8, tick=1, in_data=8'hA5 accepted -> so = 1,0,1,0,0,1,0,1 on cycles 1-8; done at cycle 9; in_ready=1 at cycle 10.
REQ-027 PARITY_EN defined, in_data=8'h07, tick=1 -> parity bit 1 on cycle 9; done at cycle 10.
REQ-028 tick high one cycle in four, in_data=8'h3C -> each bit held exactly 4 cycles; done follows the final tick by one cycle.
REQ-029 in_valid held high with second word 8'hFF during a frame -> 8'hFF not captured until in_ready=1, then sent intact as the next frame.
REQ-030 reset pulsed at cycle 4 of a frame -> so=1, so_active=0, in_ready=1 immediately; no done pulse; a new word of 8'h81 serializes correctly after reset.

Source files
------------

// File: rtl/serial_shift_ctrl.sv
// Parallel-to-serial frame controller: LSB-first data bits paced by tick, then a done pulse.
// Optional even-parity bit after the data is enabled by defining PARITY_EN.
module serial_shift_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         tick,
  output logic         so,
  output logic         so_active,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t        state, next_state;
  logic [N-1:0]  shreg;
  logic [CW-1:0] bit_cnt;
  logic          load, shift;
  logic          done_q, active_q;
`ifdef PARITY_EN
  logic          parity_q;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          shift = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
            next_state = PARITY;
`else
            next_state = DONE;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tick) next_state = DONE;
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        shreg   <= in_data;
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {1'b0, shreg[N-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
      end
      // Flag outputs are flopped from the next-state decode so they track state without glitches.
      done_q   <= (next_state == DONE);
`ifdef PARITY_EN
      active_q <= (next_state == SHIFT) || (next_state == PARITY);
`else
      active_q <= (next_state == SHIFT);
`endif
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     parity_q <= 1'b0;
    else if (load) parity_q <= ^in_data;
  end
`endif

  always_comb begin
    so = 1'b1;
    unique case (state)
      SHIFT:   so = shreg[0];
`ifdef PARITY_EN
      PARITY:  so = parity_q;
`endif
      default: so = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign so_active = active_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Self-checking bench for serial_shift_ctrl: directed vector tables, corner sequences,
// and random traffic compared against a queue-of-bits frame model.
module tb_serial_shift_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         tick;
  logic         so;
  logic         so_active;
  logic         done;

  serial_shift_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tick      (tick),
    .so        (so),
    .so_active (so_active),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int last_pop_cyc = -1;

  // Reference model: the frame still to be sent, as a queue of bits, plus a done-cycle flag.
  logic m_q[$];
  logic m_done;

  typedef struct {
    logic         v;
    logic [N-1:0] d;
    logic         t;
    logic         so;
    logic         act;
    logic         dn;
    logic         rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [N-1:0] d, input logic t,
                              input logic s, input logic a, input logic dn, input logic r);
    vec_t x;
    x.v = v; x.d = d; x.t = t; x.so = s; x.act = a; x.dn = dn; x.rdy = r;
    return x;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_done = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic step(input logic v, input logic [N-1:0] d, input logic t);
    logic e_so, e_act, e_done, e_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; tick = t;
    #1;
    if (m_q.size() > 0) begin
      e_so = m_q[0]; e_act = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
    end else if (m_done) begin
      e_so = 1'b1; e_act = 1'b0; e_done = 1'b1; e_rdy = 1'b0;
    end else begin
      e_so = 1'b1; e_act = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
    end
    check("so", so, e_so);
    check("so_active", so_active, e_act);
    check("done", done, e_done);
    check("in_ready", in_ready, e_rdy);
    if (done) done_cyc = cyc;
    if (m_q.size() > 0) begin
      if (t) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done = 1'b1;
          last_pop_cyc = cyc;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (v) begin
      for (int i = 0; i < N; i++) m_q.push_back(d[i]);
`ifdef PARITY_EN
      m_q.push_back(^d);
`endif
    end
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; tick = 1'b0;
    #1;
    check("rst_so", so, 1'b1);
    check("rst_so_active", so_active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; tick = 1'b0;
    model_clear();
    #1;
    check("init_so", so, 1'b1);
    check("init_so_active", so_active, 1'b0);
    check("init_done", done, 1'b0);
    check("init_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table, tick tied high.
`ifdef PARITY_EN
    tbl.push_back(mk(1, 8'h07, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1));
`else
    tbl.push_back(mk(1, 8'hA5, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; tick = tbl[i].t;
      #1;
      check($sformatf("tbl%0d_so", i), so, tbl[i].so);
      check($sformatf("tbl%0d_so_active", i), so_active, tbl[i].act);
      check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      cyc++;
    end

    // Slow tick: one in four cycles; done must follow the final tick by one cycle.
    apply_reset();
    done_cyc = -1; last_pop_cyc = -1;
    step(1'b1, 8'h3C, 1'b0);
    for (int r = 1; r < 4 * (N + 2) + 4; r++) step(1'b0, 8'h00, (r % 4) == 0);
    check("slow_done_after_tick", done_cyc, last_pop_cyc + 1);

    // in_valid held high with 8'hFF during a frame; it must only be taken when ready.
    apply_reset();
    step(1'b1, 8'h5A, 1'b1);
    for (int r = 0; r < 2 * (N + 3); r++) step(1'b1, 8'hFF, 1'b1);
    for (int r = 0; r < N + 4; r++) step(1'b0, 8'h00, 1'b1);

    // Reset asserted at cycle 4 of a frame aborts it with no done pulse.
    apply_reset();
    step(1'b1, 8'h55, 1'b1);
    for (int r = 0; r < 3; r++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_so", so, 1'b1);
    check("midrst_so_active", so_active, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    @(posedge clk);
    #1 check("midrst_done_edge", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    step(1'b1, 8'h81, 1'b1);
    for (int r = 0; r < N + 4; r++) step(1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int r = 0; r < 3000; r++)
      step($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
